// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encodings, parity-mode
// constants and the parity helper. Imported by the TX block and its FIFO
// interface; intended for reuse by the receiver.
package uart_pkg;

  // Width of the write-data bus presented to the transmitter.
  localparam int WDATA_W = 32;

  // Parity modes.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Parity over up to 8 data bits; unused upper bits must be zero.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake of the UART transmitter.
//   i_request : write request, held high until o_ready
//   i_wdata   : write data (only the low DATA_BITS bits are used)
//   o_ready   : one-cycle write acknowledge
//   o_full    : transmit FIFO full
//   o_empty   : transmit FIFO empty
// master = producer of writes, slave = the transmitter.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic               i_request;
  logic [WDATA_W-1:0] i_wdata;
  logic               o_ready;
  logic               o_full;
  logic               o_empty;

  modport master (
    output i_request, i_wdata,
    input  o_ready, o_full, o_empty
  );

  modport slave (
    input  i_request, i_wdata,
    output o_ready, o_full, o_empty
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through head output.
//   clk, rst : clock, asynchronous active-high reset (flushes pointers/count)
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   rdata    : current head entry
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy, $clog2(DEPTH)+1 bits
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO.
//   i_clock : the single clock
//   i_reset : asynchronous active-high reset; aborts any frame, flushes FIFO
//   wr      : write handshake (request/data/ready/full/empty), slave side
//   o_busy  : high whenever the transmitter is not idle
//   UART_TX : serial line, idle high
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS
// stop(1); every bit lasts CLOCK_RATE/BAUD_RATE clocks. When the FIFO is
// non-empty at the end of the stop bits the next frame starts with no gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  uart_tx_fifo_if.slave   wr,
  output logic            o_busy,
  output logic            UART_TX
);

  localparam int DIVISOR = CLOCK_RATE / BAUD_RATE;
  localparam int BAUD_W  = $clog2(DIVISOR);

  uart_state_t                 state, state_nxt;
  logic [BAUD_W-1:0]           baud_cnt, baud_nxt;
  logic [2:0]                  bit_cnt, bit_nxt;
  logic                        tx_q, tx_nxt;
  logic [DATA_BITS-1:0]        shift_q, shift_nxt;
  logic                        par_q, par_nxt;
  logic                        baud_tick;
  logic                        load_frame;
  logic                        pop;
  logic                        accept;
  logic                        acked;
  logic                        ready_q;
  logic [DATA_BITS-1:0]        fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_count;
  logic                        unused_wdata;
  logic [7:0]                  par_src;

  // Upper write-data bits are ignored by design.
  assign unused_wdata = ^wr.i_wdata;

  // A request is taken once; the acknowledged flag blocks re-pushing until
  // the requester drops i_request. Full is the registered FIFO count.
  assign accept = wr.i_request && !fifo_full && !acked;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clock),
    .rst   (i_reset),
    .push  (accept),
    .wdata (wr.i_wdata[DATA_BITS-1:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_count)
  );

  assign wr.o_full  = fifo_full;
  assign wr.o_empty = fifo_empty;
  assign wr.o_ready = ready_q;
  assign o_busy     = (state != ST_IDLE);
  assign UART_TX    = tx_q;
  assign baud_tick  = (baud_cnt == BAUD_W'(DIVISOR - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acked   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= accept;
      if (!wr.i_request) begin
        acked <= 1'b0;
      end else if (accept) begin
        acked <= 1'b1;
      end
    end
  end

  // Zero-extend the FIFO head for the parity helper.
  always_comb begin
    par_src                = '0;
    par_src[DATA_BITS-1:0] = fifo_rdata;
  end

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt + BAUD_W'(1);
    bit_nxt    = bit_cnt;
    tx_nxt     = tx_q;
    shift_nxt  = shift_q;
    par_nxt    = par_q;
    load_frame = 1'b0;
    pop        = 1'b0;

    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        if (!fifo_empty) begin
          load_frame = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shift_q[0];
          shift_nxt = shift_q >> 1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_nxt = '0;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_nxt = '0;
            if (PARITY != PARITY_NONE) begin
              tx_nxt    = par_q;
              state_nxt = ST_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = ST_STOP;
            end
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            tx_nxt    = shift_q[0];
            shift_nxt = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          baud_nxt = '0;
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              load_frame = 1'b1;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        baud_nxt  = '0;
        tx_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase

    // Frame start: pop the head, restart the bit timer and drop the line.
    if (load_frame) begin
      pop       = 1'b1;
      shift_nxt = fifo_rdata;
      par_nxt   = parity_bit(par_src, PARITY);
      baud_nxt  = '0;
      bit_nxt   = '0;
      tx_nxt    = 1'b0;
      state_nxt = ST_START;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_q     <= tx_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    shift_q <= shift_nxt;
    par_q   <= par_nxt;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five instances (8N1, 8E1, 8O1, 7N2, 8N1 with a
// 4-entry FIFO), all with a 10-clock bit period. Directed frame vectors are
// table-driven; hold, back-to-back/full and mid-frame reset are hand sequences.
module tb_uart_tx_fifo;

  localparam int CLK_RATE = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 10;
  localparam int NINST    = 5;
  localparam int NVEC     = 8;

  typedef struct packed {
    int          inst;
    logic [31:0] data;
    int          nbits;
    logic [15:0] bits;   // transmission order, first bit at position nbits-1
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NINST-1:0] req;
  logic [31:0]      wdata [NINST];
  logic [NINST-1:0] rdy, full, empty, busy, tx;

  int   sel = 0;
  int   rdy_cnt = 0;
  logic cap_tx [$];
  logic cap_busy [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if if0 ();
  uart_tx_fifo_if if1 ();
  uart_tx_fifo_if if2 ();
  uart_tx_fifo_if if3 ();
  uart_tx_fifo_if if4 ();

  assign if0.i_request = req[0];  assign if0.i_wdata = wdata[0];
  assign if1.i_request = req[1];  assign if1.i_wdata = wdata[1];
  assign if2.i_request = req[2];  assign if2.i_wdata = wdata[2];
  assign if3.i_request = req[3];  assign if3.i_wdata = wdata[3];
  assign if4.i_request = req[4];  assign if4.i_wdata = wdata[4];

  assign rdy   = {if4.o_ready, if3.o_ready, if2.o_ready, if1.o_ready, if0.o_ready};
  assign full  = {if4.o_full,  if3.o_full,  if2.o_full,  if1.o_full,  if0.o_full};
  assign empty = {if4.o_empty, if3.o_empty, if2.o_empty, if1.o_empty, if0.o_empty};

  uart_tx_fifo #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD)) dut0 (
    .i_clock(clk), .i_reset(rst), .wr(if0), .o_busy(busy[0]), .UART_TX(tx[0]));
  uart_tx_fifo #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .PARITY(2)) dut1 (
    .i_clock(clk), .i_reset(rst), .wr(if1), .o_busy(busy[1]), .UART_TX(tx[1]));
  uart_tx_fifo #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .PARITY(1)) dut2 (
    .i_clock(clk), .i_reset(rst), .wr(if2), .o_busy(busy[2]), .UART_TX(tx[2]));
  uart_tx_fifo #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(7),
                 .STOP_BITS(2)) dut3 (
    .i_clock(clk), .i_reset(rst), .wr(if3), .o_busy(busy[3]), .UART_TX(tx[3]));
  uart_tx_fifo #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .FIFO_DEPTH(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .wr(if4), .o_busy(busy[4]), .UART_TX(tx[4]));

  // Line/busy recorder for the selected instance, sampled mid-cycle.
  always @(negedge clk) begin
    cap_tx.push_back(tx[sel]);
    cap_busy.push_back(busy[sel]);
    if (rdy[sel]) rdy_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One full handshake: an idle-low edge, then request until acknowledged.
  task automatic do_write(input int inst, input logic [31:0] d, output int waited);
    @(posedge clk); #1;
    req[inst]   = 1'b1;
    wdata[inst] = d;
    waited      = 0;
    while (1) begin
      @(posedge clk); #1;
      waited++;
      if (rdy[inst] || waited >= 2000) break;
    end
    req[inst] = 1'b0;
    if (waited >= 2000) chk("write_timeout", waited, 0);
  endtask

  function automatic int find_low(input int from);
    for (int i = from; i < cap_tx.size(); i++)
      if (cap_tx[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int count_errs(input int start, input logic [15:0] bits,
                                    input int nbits);
    int e = 0;
    if (start < 0) return nbits * DIV;
    for (int k = 0; k < nbits; k++)
      for (int j = 0; j < DIV; j++) begin
        int idx = start + k * DIV + j;
        if (idx >= cap_tx.size()) e++;
        else if (cap_tx[idx] !== bits[nbits-1-k]) e++;
      end
    return e;
  endfunction

  function automatic int busy_cycles(input int from);
    int c = 0;
    for (int i = from; i < cap_busy.size(); i++) if (cap_busy[i]) c++;
    return c;
  endfunction

  function automatic int low_cycles(input int from);
    int c = 0;
    for (int i = from; i < cap_tx.size(); i++) if (!cap_tx[i]) c++;
    return c;
  endfunction

  // 8N1 frame in transmission order: start, d[0]..d[7], stop.
  function automatic logic [15:0] frame_8n1(input logic [7:0] d);
    logic [15:0] b = '0;
    b[9] = 1'b0;
    for (int k = 0; k < 8; k++) b[8-k] = d[k];
    b[0] = 1'b1;
    return b;
  endfunction

  vec_t        vecs [NVEC];
  logic [7:0]  bytes6 [6];

  initial begin
    int w, base, r0, st, errs;

    vecs[0] = '{0, 32'h0000_00A5, 10, 16'b0101001011};
    vecs[1] = '{0, 32'h0000_0000, 10, 16'b0000000001};
    vecs[2] = '{0, 32'h1234_5603, 10, 16'b0110000001};
    vecs[3] = '{1, 32'h0000_00A5, 11, 16'b01010010101};
    vecs[4] = '{2, 32'h0000_00A5, 11, 16'b01010010111};
    vecs[5] = '{1, 32'h0000_0001, 11, 16'b01000000011};
    vecs[6] = '{3, 32'h0000_00C1, 10, 16'b0100000111};
    vecs[7] = '{3, 32'h0000_007E, 10, 16'b0011111111};
    bytes6  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NINST; i++) wdata[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",    int'(tx),    5'h1F);
    chk("rst_empty", int'(empty), 5'h1F);
    chk("rst_full",  int'(full),  0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_ready", int'(rdy),   0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed single-frame vectors
    for (int v = 0; v < NVEC; v++) begin
      sel  = vecs[v].inst;
      #1;
      base = cap_tx.size();
      do_write(vecs[v].inst, vecs[v].data, w);
      chk($sformatf("v%0d_ready_tx_high", v), int'(tx[vecs[v].inst]), 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_latency_low", v), int'(tx[vecs[v].inst]), 0);
      repeat (vecs[v].nbits * DIV + 20) @(posedge clk);
      #1;
      errs = count_errs(find_low(base), vecs[v].bits, vecs[v].nbits);
      chk($sformatf("v%0d_frame_bits", v), errs, 0);
      chk($sformatf("v%0d_busy_cycles", v), busy_cycles(base), vecs[v].nbits * DIV);
      chk($sformatf("v%0d_idle_line", v), int'(tx[vecs[v].inst]), 1);
      chk($sformatf("v%0d_empty", v), int'(empty[vecs[v].inst]), 1);
    end

    // Request held high after acknowledge: exactly one push
    sel = 0;
    @(posedge clk); #1;
    base = cap_tx.size();
    r0   = rdy_cnt;
    req[0]   = 1'b1;
    wdata[0] = 32'h0000_005A;
    repeat (40) @(posedge clk);
    #1;
    chk("hold_ready_pulses", rdy_cnt - r0, 1);
    req[0] = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    chk("hold_busy_cycles", busy_cycles(base), 100);
    chk("hold_frame_bits", count_errs(find_low(base), frame_8n1(8'h5A), 10), 0);
    chk("hold_empty", int'(empty[0]), 1);

    // Back-to-back writes into a 4-deep FIFO
    sel = 4;
    @(posedge clk); #1;
    base = cap_tx.size();
    r0   = rdy_cnt;
    for (int i = 0; i < 6; i++) begin
      do_write(4, {24'h0, bytes6[i]}, w);
      if (i == 3) chk("b2b_not_full_after_4", int'(full[4]), 0);
      if (i == 4) chk("b2b_full_after_5", int'(full[4]), 1);
      if (i == 5) chk("b2b_sixth_stalled", int'(w > 50), 1);
    end
    w = 0;
    while (busy[4] && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("b2b_drain_timeout", int'(w >= 1000), 0);
    st   = find_low(base);
    errs = 0;
    for (int f = 0; f < 6; f++)
      errs += count_errs((st < 0) ? -1 : st + f * 100, frame_8n1(bytes6[f]), 10);
    chk("b2b_frame_bits", errs, 0);
    chk("b2b_busy_cycles", busy_cycles(base), 600);
    chk("b2b_ready_pulses", rdy_cnt - r0, 6);

    // Reset 35 cycles into a frame with three bytes queued
    sel = 0;
    do_write(0, 32'h0000_0000, w);   // frame starts at the next edge
    do_write(0, 32'h0000_0011, w);
    do_write(0, 32'h0000_0022, w);
    do_write(0, 32'h0000_0033, w);
    repeat (29) @(posedge clk);
    #1;
    chk("mid_pre_line_low", int'(tx[0]), 0);
    chk("mid_pre_not_empty", int'(empty[0]), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_line_high", int'(tx[0]), 1);
    chk("mid_rst_empty", int'(empty[0]), 1);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_ready", int'(rdy[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cap_tx.size();
    repeat (300) @(posedge clk);
    #1;
    chk("mid_post_low_cycles", low_cycles(base), 0);
    chk("mid_post_busy_cycles", busy_cycles(base), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
